// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//
// Signals:
//   PC          - fetch address, driven by the fetch stage.
//   instruction - word returned combinationally by memory for PC.
//
// Modports:
//   master - the fetch stage (drives PC, receives instruction).
//   slave  - the instruction memory (receives PC, drives instruction).
interface fetch_unit_if;
  logic [31:0] PC;
  logic [31:0] instruction;

  modport master (output PC, input instruction);
  modport slave  (input PC, output instruction);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. It presents the program counter to instruction
// memory and captures the returned word into the IF/ID pipeline register.
// It handles sequential fetch, hazard stalls and branch/jump redirects.
// A misaligned redirect target halts fetch until the next reset.
//
// Parameters:
//   RESET_PC  - PC value loaded on reset.
//   NOP_INSTR - word placed in if_id_instr for every bubble.
//
// Ports:
//   SYS_clk          - clock; all state updates on the rising edge.
//   SYS_reset        - synchronous reset, active low.
//   stall            - hold the PC and the IF/ID register this cycle.
//   redirect_valid   - a branch or jump was taken; load redirect_pc.
//   redirect_pc      - redirect target (byte address).
//   imem             - instruction-memory bus (PC out, instruction in).
//   if_id_valid      - the IF/ID register holds a real instruction.
//   if_id_instr      - fetched instruction.
//   if_id_pc         - address of if_id_instr.
//   if_id_pc_plus4   - if_id_pc + 4.
//   fetch_fault      - sticky flag: a misaligned redirect was received.
//   fault_pc         - the offending redirect target.
//   perf_fetch_count - instructions loaded into IF/ID.
//   perf_stall_count - stalled RUN cycles.
//
// Optional feature: define FETCH_PERF_CNT_EN to build the two performance
// counters. Without it, both counter outputs are tied to 0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               SYS_clk,
  input  logic               SYS_reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  fetch_unit_if.master       imem,
  output logic               if_id_valid,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc_plus4,
  output logic               fetch_fault,
  output logic [31:0]        fault_pc,
  output logic [31:0]        perf_fetch_count,
  output logic [31:0]        perf_stall_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifpc4_q, ifpc4_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  // One-cycle pulses that drive the performance counters.
  logic        fetch_evt;
  logic        stall_evt;

  // 32-bit add: wraps modulo 2^32 with no carry out.
  logic [31:0] pc_plus4;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // can leave it unassigned and infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    ifpc_d     = ifpc_q;
    ifpc4_d    = ifpc4_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    fetch_evt  = 1'b0;
    stall_evt  = 1'b0;

    unique case (state_q)
      // Gives instruction memory its post-reset load cycle. The PC is held
      // and IF/ID still holds the bubble loaded at reset.
      BOOT: state_d = RUN;

      RUN: begin
        if (redirect_valid) begin
          // A redirect overrides stall and always squashes the IF/ID entry.
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (redirect_pc[1:0] == 2'b00) begin
            pc_d = redirect_pc;
          end else begin
            fault_d    = 1'b1;
            fault_pc_d = redirect_pc;
            state_d    = HALT;
          end
        end else if (stall) begin
          stall_evt = 1'b1;
        end else begin
          instr_d   = imem.instruction;
          ifpc_d    = pc_q;
          ifpc4_d   = pc_plus4;
          valid_d   = 1'b1;
          pc_d      = pc_plus4;
          fetch_evt = 1'b1;
        end
      end

      // Only reset leaves HALT. The bubble loaded on the faulting edge stays.
      HALT: state_d = HALT;

      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      ifpc_q     <= '0;
      ifpc4_q    <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments, so every
      // register samples its pre-edge value on the same clock edge.
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      ifpc_q     <= ifpc_d;
      ifpc4_q    <= ifpc4_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {31'd0, fetch_evt};
    stall_cnt_d = stall_cnt_q + {31'd0, stall_evt};
  end

  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_count = fetch_cnt_q;
  assign perf_stall_count = stall_cnt_q;
`else
  logic unused_evt;
  assign unused_evt       = fetch_evt ^ stall_evt;
  assign perf_fetch_count = '0;
  assign perf_stall_count = '0;
`endif

  // PC comes straight from a register, so no input reaches it combinationally.
  assign imem.PC        = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = ifpc_q;
  assign if_id_pc_plus4 = ifpc4_q;
  assign fetch_fault    = fault_q;
  assign fault_pc       = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. Instance u0 uses the default
// parameters and is tracked every cycle by a cycle-level model. Instance u1
// uses RESET_PC = 32'hFFFF_FFF8 to cover PC wrap-around after reset.
// Instruction memory returns 32'hA000_0000 + byte address.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        SYS_reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_unit_if imem0 ();
  fetch_unit_if imem1 ();
  assign imem0.instruction = 32'hA000_0000 + imem0.PC;
  assign imem1.instruction = 32'hA000_0000 + imem1.PC;

  logic        v0, v1, ff0, ff1;
  logic [31:0] ins0, pc0, pc40, fpc0, pfc0, psc0;
  logic [31:0] ins1, pc1, pc41, fpc1, pfc1, psc1;

  fetch_unit u0 (
    .SYS_clk(clk), .SYS_reset(SYS_reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem(imem0), .if_id_valid(v0), .if_id_instr(ins0),
    .if_id_pc(pc0), .if_id_pc_plus4(pc40), .fetch_fault(ff0),
    .fault_pc(fpc0), .perf_fetch_count(pfc0), .perf_stall_count(psc0)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u1 (
    .SYS_clk(clk), .SYS_reset(SYS_reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem(imem1), .if_id_valid(v1), .if_id_instr(ins1),
    .if_id_pc(pc1), .if_id_pc_plus4(pc41), .fetch_fault(ff1),
    .fault_pc(fpc1), .perf_fetch_count(pfc1), .perf_stall_count(psc1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of u0 ----------------
  logic [31:0] m_pc, m_instr, m_ifpc, m_fault_pc, m_fetches, m_stalls;
  logic        m_valid, m_fault, m_boot, m_halt;
  bit          cmp_en = 1'b0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  task automatic model_step(input logic rst, input logic st, input logic rv,
                            input logic [31:0] rpc);
    if (!rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP; m_ifpc = 32'h0;
      m_fault = 1'b0; m_fault_pc = 32'h0; m_fetches = 32'h0; m_stalls = 32'h0;
      m_boot = 1'b1; m_halt = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halt) begin
      // inputs ignored
    end else if (rv) begin
      m_valid = 1'b0;
      m_instr = NOP;
      if (rpc[1:0] == 2'b00) m_pc = rpc;
      else begin m_fault = 1'b1; m_fault_pc = rpc; m_halt = 1'b1; end
    end else if (st) begin
      m_stalls++;
    end else begin
      m_ifpc  = m_pc;
      m_instr = mem(m_pc);
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
      m_fetches++;
    end
  endtask

  // Compare process: outputs checked mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_pc", imem0.PC, m_pc);
      check("m_valid", v0, m_valid);
      check("m_instr", ins0, m_instr);
      check("m_fault", ff0, m_fault);
      check("m_fault_pc", fpc0, m_fault_pc);
      if (m_valid) begin
        check("m_ifpc", pc0, m_ifpc);
        check("m_ifpc4", pc40, m_ifpc + 32'd4);
      end
`ifdef FETCH_PERF_CNT_EN
      check("m_perf_fetch", pfc0, m_fetches);
      check("m_perf_stall", psc0, m_stalls);
`else
      check("m_perf_fetch", pfc0, 32'h0);
      check("m_perf_stall", psc0, 32'h0);
`endif
    end
  end

  // One clock: drive inputs, take the edge, advance the model, and return
  // at the following falling edge.
  task automatic cycle(input logic rst, input logic st, input logic rv,
                       input logic [31:0] rpc);
    SYS_reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk);
    model_step(rst, st, rv, rpc);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"}, imem0.PC, 32'h0);
    check({tag, "_valid"}, v0, 1'b0);
    check({tag, "_instr"}, ins0, NOP);
    check({tag, "_ifpc"}, pc0, 32'h0);
    check({tag, "_ifpc4"}, pc40, 32'h0);
    check({tag, "_fault"}, ff0, 1'b0);
    check({tag, "_fault_pc"}, fpc0, 32'h0);
    check({tag, "_pfc"}, pfc0, 32'h0);
    check({tag, "_psc"}, psc0, 32'h0);
  endtask

  initial begin
    bit reached;
    // Reset for two edges.
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cmp_en = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check_reset_vals("rst");
    check("rst_u1_pc", imem1.PC, 32'hFFFF_FFF8);

    // Release: BOOT cycle holds PC.
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("boot_pc", imem0.PC, 32'h0);
    check("boot_valid", v0, 1'b0);
    check("boot_u1_pc", imem1.PC, 32'hFFFF_FFF8);

    // First valid entry on 2nd edge after release.
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("first_valid", v0, 1'b1);
    check("first_instr", ins0, 32'hA000_0000);
    check("first_ifpc", pc0, 32'h0);
    check("first_ifpc4", pc40, 32'h4);
    check("first_pc", imem0.PC, 32'h4);
    check("wrap_u1_pc_a", imem1.PC, 32'hFFFF_FFFC);

    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("run_pc8", imem0.PC, 32'h8);
    check("wrap_u1_pc_b", imem1.PC, 32'h0);

    // Stall 3 cycles at PC=8.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("stall_pc", imem0.PC, 32'h8);
    check("stall_ifpc", pc0, 32'h4);
    check("stall_instr", ins0, 32'hA000_0004);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("post_stall_ifpc", pc0, 32'h8);
    check("post_stall_pc", imem0.PC, 32'hC);
`ifdef FETCH_PERF_CNT_EN
    check("post_stall_psc", psc0, 32'd3);
`else
    check("post_stall_psc", psc0, 32'd0);
`endif
    check("wrap_u1_pc_c", imem1.PC, 32'h4);

    // Redirect together with stall: redirect wins.
    cycle(1'b1, 1'b1, 1'b1, 32'h100);
    check("redir_pc", imem0.PC, 32'h100);
    check("redir_valid", v0, 1'b0);
    check("redir_instr", ins0, NOP);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("redir_ifpc", pc0, 32'h100);
    check("redir_tgt_instr", ins0, 32'hA000_0100);

    // Redirect near the top of the address space: PC wraps to 0.
    cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_ifpc", pc0, 32'hFFFF_FFFC);
    check("wrap_ifpc4", pc40, 32'h0);
    check("wrap_pc", imem0.PC, 32'h0);

    // Free-run to PC=0x40 (bounded), then pulse reset there.
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      if (imem0.PC == 32'h40) reached = 1'b1;
      else cycle(1'b1, 1'b0, 1'b0, 32'h0);
    end
    check("reach_pc40", imem0.PC, 32'h40);
    cycle(1'b0, 1'b0, 1'b1, 32'h200);
    check_reset_vals("midrst");
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("reboot_pc", imem0.PC, 32'h0);
    check("reboot_valid", v0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("rerun_valid", v0, 1'b1);
    check("rerun_ifpc", pc0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // Misaligned redirect at PC=8: halt with fault.
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0102);
    check("fault_flag", ff0, 1'b1);
    check("fault_pc", fpc0, 32'h102);
    check("fault_hold_pc", imem0.PC, 32'h8);
    check("fault_valid", v0, 1'b0);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, i[0], i[1], 32'(i) * 32'd4);
    check("halt_valid", v0, 1'b0);
    check("halt_pc", imem0.PC, 32'h8);
    check("halt_fault", ff0, 1'b1);

    // Reset clears the fault and restarts from RESET_PC.
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    check("clr_fault", ff0, 1'b0);
    check("clr_fault_pc", fpc0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("restart_valid", v0, 1'b1);
    check("restart_ifpc", pc0, 32'h0);
    check("restart_instr", ins0, 32'hA000_0000);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
